hash_result_scanner: RTL

//  Downstream of the bitcoin_hash stage. It reads the NUM_NONCES 32-bit H0 words written by that stage

---
 rtl/hash_result_scanner_if.sv | 27 ++
 rtl/hash_result_scanner.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hash_result_scanner_if.sv
// Control and shared-memory signals of hash_result_scanner.
// The master side drives the scan request and the memory read data; the slave side is the scanner.
interface hash_result_scanner_if;
  logic        start;
  logic [15:0] result_addr;
  logic [15:0] report_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [7:0]  winner_nonce;

  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output start, result_addr, report_addr, target, mem_read_data,
    input  done, found, winner_nonce, mem_clk, mem_we, mem_addr, mem_write_data
  );

  modport slave (
    input  start, result_addr, report_addr, target, mem_read_data,
    output done, found, winner_nonce, mem_clk, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/hash_result_scanner.sv
// Scans NUM_NONCES H0 words in shared memory against a difficulty target, tracks the first hit and
// the minimum hash, then writes a 4-word report {found, winner, min_hash, min_nonce} back to memory.
module hash_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hash_result_scanner_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  localparam logic [8:0] LAST_IDX     = 9'(NUM_NONCES);
  localparam logic [8:0] LAST_REPORT  = 9'd3;
  localparam logic [7:0] NO_WINNER    = 8'hFF;
  localparam logic [31:0] MIN_INIT    = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [15:0] res_base_q, res_base_d;
  logic [15:0] rep_base_q, rep_base_d;
  logic [31:0] target_q, target_d;

  // Running results of the scan in progress.
  logic        hit_q, hit_d;
  logic [7:0]  win_q, win_d;
  logic [31:0] min_hash_q, min_hash_d;
  logic [7:0]  min_nonce_q, min_nonce_d;

  // Port-visible results, refreshed only when a scan completes.
  logic        found_q, found_d;
  logic [7:0]  winner_q, winner_d;

  logic [7:0]  eval_nonce;
  logic [31:0] hash;

  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;

  assign hash = bus.mem_read_data;
  // In SCAN, the word arriving now was addressed one cycle earlier.
  assign eval_nonce = idx_q[7:0] - 8'd1;

  // NOTE: every _d gets its _q as a default before the case, so no path leaves a variable unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    res_base_d  = res_base_q;
    rep_base_d  = rep_base_q;
    target_d    = target_q;
    hit_d       = hit_q;
    win_d       = win_q;
    min_hash_d  = min_hash_q;
    min_nonce_d = min_nonce_q;
    found_d     = found_q;
    winner_d    = winner_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          res_base_d  = bus.result_addr;
          rep_base_d  = bus.report_addr;
          target_d    = bus.target;
          idx_d       = '0;
          hit_d       = 1'b0;
          win_d       = NO_WINNER;
          min_hash_d  = MIN_INIT;
          min_nonce_d = '0;
          state_d     = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (idx_q != '0) begin
          if ((hash < target_q) && !hit_q) begin
            hit_d = 1'b1;
            win_d = eval_nonce;
          end
          // Strict compare: equal hashes keep the earlier nonce.
          if (hash < min_hash_q) begin
            min_hash_d  = hash;
            min_nonce_d = eval_nonce;
          end
        end

        if (idx_q == LAST_IDX) begin
          idx_d    = '0;
          found_d  = hit_d;
          winner_d = win_d;
          state_d  = ST_WRITE;
        end else begin
          idx_d = idx_q + 9'd1;
        end
      end

      ST_WRITE: begin
        if (idx_q == LAST_REPORT) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 9'd1;
        end
      end

      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: all state is reset, including the latched bases and running results, so a scan aborted by
  // reset cannot leak stale values into the next report.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      res_base_q  <= '0;
      rep_base_q  <= '0;
      target_q    <= '0;
      hit_q       <= 1'b0;
      win_q       <= NO_WINNER;
      min_hash_q  <= MIN_INIT;
      min_nonce_q <= '0;
      found_q     <= 1'b0;
      winner_q    <= NO_WINNER;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      res_base_q  <= res_base_d;
      rep_base_q  <= rep_base_d;
      target_q    <= target_d;
      hit_q       <= hit_d;
      win_q       <= win_d;
      min_hash_q  <= min_hash_d;
      min_nonce_q <= min_nonce_d;
      found_q     <= found_d;
      winner_q    <= winner_d;
    end
  end

  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;

    unique case (state_q)
      ST_SCAN: begin
        mem_addr = res_base_q + 16'(idx_q);
      end

      ST_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = rep_base_q + 16'(idx_q);
        unique case (idx_q[1:0])
          2'd0:    mem_write_data = {31'b0, hit_q};
          2'd1:    mem_write_data = hit_q ? {24'b0, win_q} : 32'hFFFF_FFFF;
          2'd2:    mem_write_data = min_hash_q;
          default: mem_write_data = {24'b0, min_nonce_q};
        endcase
      end

      default: ;
    endcase
  end

  assign bus.mem_clk        = clk;
  assign bus.mem_we         = mem_we;
  assign bus.mem_addr       = mem_addr;
  assign bus.mem_write_data = mem_write_data;
  assign bus.done           = (state_q == ST_IDLE);
  assign bus.found          = found_q;
  assign bus.winner_nonce   = winner_q;

endmodule
